// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the clock time-set controller.
// Holds the FSM state encoding, the button-owner select type and the
// default timing constants for a 100 MHz core clock.
package time_set_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_REPEAT   = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_e;

  // Which button owns the HOLD/REPEAT sequence.
  typedef enum logic {
    SEL_HOUR = 1'b0,
    SEL_MIN  = 1'b1
  } sel_e;

  localparam int unsigned DEF_HOLD_CYCLES   = 50_000_000; // 0.5 s
  localparam int unsigned DEF_REPEAT_CYCLES = 20_000_000; // 0.2 s
  localparam int unsigned DEF_BLINK_CYCLES  = 25_000_000; // 0.25 s half-period
  localparam int unsigned DEF_CNT_W         = 27;

endpackage

// File: rtl/time_set_ctrl_edge_detect.sv
// edge_detect: rising-edge detector for one debounced button level.
// Latency: rise_o is combinational from lvl_i against a 1-cycle delayed copy.
// Backpressure: none; free-running.
// Ports: clk_i clock, rst_ni sync active-low reset, lvl_i button level,
//        rise_o high while lvl_i=1 and the previous level was 0.
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic lvl_i,
  output logic rise_o
);

  logic lvl_q;

  // Reset loads the live level too, so a button held through reset is
  // treated as already pressed and never produces a rise.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lvl_q <= lvl_i;
    end else begin
      lvl_q <= lvl_i;
    end
  end

  assign rise_o = lvl_i & ~lvl_q;

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: time-set sequencer producing hour/min increment pulses with
//   hold-to-auto-repeat, a seconds-clear pulse and a set-mode blink enable.
// Latency: every output is registered, 1 cycle after the triggering edge/count.
// Backpressure: none; pulses are fire-and-forget single-cycle strobes.
// Ports: Clk_100M clock, Reset_n sync active-low reset, hour_btn/min_btn/
//   mode_btn debounced levels; set_mode, hour_inc, min_inc, sec_clr, blink out.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned BLINK_CYCLES  = DEF_BLINK_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic Clk_100M,
  input  logic Reset_n,
  input  logic hour_btn,
  input  logic min_btn,
  input  logic mode_btn,
  output logic set_mode,
  output logic hour_inc,
  output logic min_inc,
  output logic sec_clr,
  output logic blink
);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_CYCLES - 1);

  logic hour_rise, min_rise, mode_rise;

  edge_detect u_hour_ed (.clk_i(Clk_100M), .rst_ni(Reset_n), .lvl_i(hour_btn), .rise_o(hour_rise));
  edge_detect u_min_ed  (.clk_i(Clk_100M), .rst_ni(Reset_n), .lvl_i(min_btn),  .rise_o(min_rise));
  edge_detect u_mode_ed (.clk_i(Clk_100M), .rst_ni(Reset_n), .lvl_i(mode_btn), .rise_o(mode_rise));

  state_e           state_q, state_d;
  sel_e             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             set_mode_q, set_mode_d;
  logic             blink_q, blink_d;
  logic             hour_inc_q, hour_inc_d;
  logic             min_inc_q, min_inc_d;
  logic             sec_clr_q, sec_clr_d;

  logic sel_lvl;
  logic mode_exit;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    set_mode_d  = set_mode_q;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    hour_inc_d  = 1'b0;
    min_inc_d   = 1'b0;
    sec_clr_d   = 1'b0;

    sel_lvl   = (sel_q == SEL_MIN) ? min_btn : hour_btn;
    mode_exit = mode_rise & set_mode_q;

    if (mode_rise) begin
      set_mode_d = ~set_mode_q;
    end

    // Leaving set mode overrides whatever the FSM would have done this
    // cycle, including a terminal-count pulse.
    if (mode_exit) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (set_mode_q) begin
            if (hour_rise && min_rise) begin
              sec_clr_d = 1'b1;
              state_d   = ST_WAIT_REL;
            end else if (hour_rise) begin
              hour_inc_d = 1'b1;
              sel_d      = SEL_HOUR;
              cnt_d      = '0;
              state_d    = ST_HOLD;
            end else if (min_rise) begin
              min_inc_d = 1'b1;
              sel_d     = SEL_MIN;
              cnt_d     = '0;
              state_d   = ST_HOLD;
            end
          end
        end
        ST_HOLD, ST_REPEAT: begin
          // Release is checked first so it beats a coincident terminal count.
          if (!sel_lvl) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == ((state_q == ST_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
            hour_inc_d = (sel_q == SEL_HOUR);
            min_inc_d  = (sel_q == SEL_MIN);
            cnt_d      = '0;
            state_d    = ST_REPEAT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_REL: begin
          if (!hour_btn && !min_btn) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Blink starts high on entry so the display visibly reacts at once.
    if (mode_exit) begin
      blink_d     = 1'b0;
      blink_cnt_d = '0;
    end else if (mode_rise) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (set_mode_q) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk_100M) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= SEL_HOUR;
      cnt_q       <= '0;
      blink_cnt_q <= '0;
      set_mode_q  <= 1'b0;
      blink_q     <= 1'b0;
      hour_inc_q  <= 1'b0;
      min_inc_q   <= 1'b0;
      sec_clr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      blink_cnt_q <= blink_cnt_d;
      set_mode_q  <= set_mode_d;
      blink_q     <= blink_d;
      hour_inc_q  <= hour_inc_d;
      min_inc_q   <= min_inc_d;
      sec_clr_q   <= sec_clr_d;
    end
  end

  assign set_mode = set_mode_q;
  assign hour_inc = hour_inc_q;
  assign min_inc  = min_inc_q;
  assign sec_clr  = sec_clr_q;
  assign blink    = blink_q;

endmodule
